// File: rtl/wisc_pkg.sv
// Shared defaults for the register file: width, depth and read-port count,
// plus the write-counter width and its saturating increment.
package wisc_pkg;

   localparam int DATA_W_DEF = 16;
   localparam int ADDR_W_DEF = 4;
   localparam int NUM_RD_DEF = 2;
   localparam int WR_CNT_W   = 8;

   typedef logic [WR_CNT_W-1:0] wr_cnt_t;

   function automatic wr_cnt_t sat_inc(input wr_cnt_t c);
      return (c == '1) ? c : c + wr_cnt_t'(1);
   endfunction

endpackage

// File: rtl/reg_file_param_decoder.sv
// decoder_param: ADDR_W-to-2**ADDR_W one-hot decoder with enable; all-zero
// output when disabled. Drives the register file write wordline.
module decoder_param #(
   parameter int IN_W = 4
) (
   input  logic [IN_W-1:0]      addr,
   input  logic                 en,
   output logic [2**IN_W-1:0]   onehot
);

   always_comb begin
      onehot = '0;
      if (en) onehot[addr] = 1'b1;
   end

endmodule

// File: rtl/reg_file_param.sv
// Parametrised multi-read, single-write register file with optional hard-wired
// zero register, saturating write counter and optional write-to-read bypass
// (enabled by defining REG_FILE_BYPASS_EN).
module reg_file_param
   import wisc_pkg::*;
#(
   parameter int DATA_W  = DATA_W_DEF,
   parameter int ADDR_W  = ADDR_W_DEF,
   parameter int NUM_RD  = NUM_RD_DEF,
   parameter int ZERO_R0 = 1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     WriteReg,
   input  logic [ADDR_W-1:0]        DstReg,
   input  logic [DATA_W-1:0]        DstData,
   input  logic [NUM_RD*ADDR_W-1:0] SrcReg,
   output logic [NUM_RD*DATA_W-1:0] SrcData,
   output logic [WR_CNT_W-1:0]      WrCount
);

   localparam int DEPTH = 2**ADDR_W;

   logic [DATA_W-1:0] regs [DEPTH];
   logic [DEPTH-1:0]  wordline;
   logic              commit;
   wr_cnt_t           wr_cnt;

   decoder_param #(.IN_W(ADDR_W)) u_wr_dec (
      .addr   (DstReg),
      .en     (WriteReg),
      .onehot (wordline)
   );

   // A write to a hard-wired zero register is not a committed write.
   assign commit = WriteReg && !((ZERO_R0 != 0) && (DstReg == '0));

   // NOTE: the array is reset explicitly because cleared contents are part of
   // the visible behaviour after reset; this keeps it out of RAM macros.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
         wr_cnt <= '0;
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            if (wordline[i] && !((ZERO_R0 != 0) && (i == 0))) regs[i] <= DstData;
         end
         if (commit) wr_cnt <= sat_inc(wr_cnt);
      end
   end

   assign WrCount = wr_cnt;

   for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;

      assign addr = SrcReg[p*ADDR_W +: ADDR_W];

      always_comb begin
         data = regs[addr];
`ifdef REG_FILE_BYPASS_EN
         if (WriteReg && !rst && (addr == DstReg)) data = DstData;
`endif
         // Zero override last so neither storage nor bypass can leak into R0.
         if ((ZERO_R0 != 0) && (addr == '0)) data = '0;
      end

      assign SrcData[p*DATA_W +: DATA_W] = data;
   end

endmodule

// File: tb/tb_reg_file_param.sv
// Directed self-checking bench for reg_file_param: default configuration plus
// a 32-bit, 32-deep, 3-read-port instance.
module tb_reg_file_param;

   logic        clk = 1'b0;
   logic        rst;

   logic        we_a;
   logic [3:0]  dst_a;
   logic [15:0] din_a;
   logic [7:0]  src_a;
   logic [31:0] dout_a;
   logic [7:0]  cnt_a;

   logic        we_b;
   logic [4:0]  dst_b;
   logic [31:0] din_b;
   logic [14:0] src_b;
   logic [95:0] dout_b;
   logic [7:0]  cnt_b;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   reg_file_param u_dut_a (
      .clk      (clk),
      .rst      (rst),
      .WriteReg (we_a),
      .DstReg   (dst_a),
      .DstData  (din_a),
      .SrcReg   (src_a),
      .SrcData  (dout_a),
      .WrCount  (cnt_a)
   );

   reg_file_param #(.DATA_W(32), .ADDR_W(5), .NUM_RD(3)) u_dut_b (
      .clk      (clk),
      .rst      (rst),
      .WriteReg (we_b),
      .DstReg   (dst_b),
      .DstData  (din_b),
      .SrcReg   (src_b),
      .SrcData  (dout_b),
      .WrCount  (cnt_b)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got=%h expected=%h", tag, got, exp);
      end
   endtask

   // Inputs change 1 time unit after the rising edge; outputs sampled 1 later.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   logic [15:0] same_cycle_exp;

   initial begin
      rst = 1'b1;
      we_a = 1'b0; dst_a = '0; din_a = '0; src_a = '0;
      we_b = 1'b0; dst_b = '0; din_b = '0; src_b = '0;
      tick();
      tick();
      rst = 1'b0;

      // First cycle after reset: everything reads zero
      src_a = {4'd9, 4'd5};
      src_b = {5'd31, 5'd17, 5'd2};
      settle();
      check("rst_p0", 32'(dout_a[15:0]), 32'h0);
      check("rst_p1", 32'(dout_a[31:16]), 32'h0);
      check("rst_cnt", 32'(cnt_a), 32'd0);
      check("rst_b", 32'(dout_b[31:0] | dout_b[63:32] | dout_b[95:64]), 32'h0);

      // Basic write/read
      we_a = 1'b1; dst_a = 4'd5; din_a = 16'hBEEF;
      tick();
      we_a = 1'b1; dst_a = 4'd3; din_a = 16'h0001;
      src_a = {4'd5, 4'd5};
      settle();
      check("wr_p0", 32'(dout_a[15:0]), 32'hBEEF);
      check("wr_p1", 32'(dout_a[31:16]), 32'hBEEF);
      check("wr_cnt", 32'(cnt_a), 32'd1);
      tick();
      we_a = 1'b0;
      check("wr_cnt2", 32'(cnt_a), 32'd2);

      // R0 protection, including same-cycle write to R0
      we_a = 1'b1; dst_a = 4'd0; din_a = 16'h1234; src_a = {4'd0, 4'd0};
      settle();
      check("r0_same", 32'(dout_a[15:0]), 32'h0);
      tick();
      we_a = 1'b0;
      settle();
      check("r0_p0", 32'(dout_a[15:0]), 32'h0);
      check("r0_p1", 32'(dout_a[31:16]), 32'h0);
      check("r0_cnt", 32'(cnt_a), 32'd2);

      // Same-cycle write and read of R3
      src_a = {4'd3, 4'd3};
      settle();
      check("r3_hold", 32'(dout_a[15:0]), 32'h0001);
      we_a = 1'b1; dst_a = 4'd3; din_a = 16'h00FF;
      settle();
`ifdef REG_FILE_BYPASS_EN
      same_cycle_exp = 16'h00FF;
`else
      same_cycle_exp = 16'h0001;
`endif
      check("byp_p0", 32'(dout_a[15:0]), 32'(same_cycle_exp));
      check("byp_p1", 32'(dout_a[31:16]), 32'(same_cycle_exp));
      tick();
      we_a = 1'b0;
      settle();
      check("r3_next", 32'(dout_a[15:0]), 32'h00FF);

      // WriteReg=0 leaves contents alone
      dst_a = 4'd3; din_a = 16'h5555;
      tick();
      check("no_we", 32'(dout_a[15:0]), 32'h00FF);
      check("no_we_cnt", 32'(cnt_a), 32'd3);

      // Reset beats a simultaneous write
      rst = 1'b1; we_a = 1'b1; dst_a = 4'd7; din_a = 16'hAAAA; src_a = {4'd7, 4'd7};
      settle();
      check("rst_nobyp", 32'(dout_a[15:0]), 32'h0);
      tick();
      rst = 1'b0; we_a = 1'b0; src_a = {4'd5, 4'd7};
      settle();
      check("rstw_r7", 32'(dout_a[15:0]), 32'h0);
      check("rstw_r5", 32'(dout_a[31:16]), 32'h0);
      check("rstw_cnt", 32'(cnt_a), 32'd0);

      // 300 writes rotating through R1..R15; counter saturates at 255
      for (int i = 0; i < 300; i++) begin
         we_a = 1'b1; dst_a = 4'(1 + (i % 15)); din_a = 16'(i);
         tick();
         if (i == 253) check("cnt_254", 32'(cnt_a), 32'd254);
      end
      we_a = 1'b0;
      src_a = {4'd14, 4'd15};
      settle();
      check("sat_cnt", 32'(cnt_a), 32'd255);
      check("sat_r15", 32'(dout_a[15:0]), 32'h012B);
      check("sat_r14", 32'(dout_a[31:16]), 32'h012A);
      for (int i = 0; i < 5; i++) begin
         we_a = 1'b1; dst_a = 4'd2; din_a = 16'h7777;
         tick();
      end
      we_a = 1'b0;
      check("sat_hold", 32'(cnt_a), 32'd255);

      // Wide configuration: 32-bit data, 32 entries, 3 read ports
      we_b = 1'b1; dst_b = 5'd31; din_b = 32'hDEADBEEF;
      tick();
      we_b = 1'b0;
      src_b = {5'd31, 5'd0, 5'd31};
      settle();
      check("b_p0", dout_b[31:0], 32'hDEADBEEF);
      check("b_p1", dout_b[63:32], 32'h00000000);
      check("b_p2", dout_b[95:64], 32'hDEADBEEF);
      check("b_cnt", 32'(cnt_b), 32'd1);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/reg_file_param.md
REG_FILE_PARAM -- requirements
Module: reg_file_param

Interface
REQ-001 SHALL have parameter DATA_W, default 16: register width in bits.
REQ-002 SHALL have parameter ADDR_W, default 4: register index width; depth is 2**ADDR_W.
REQ-003 SHALL have parameter NUM_RD, default 2: number of independent read ports, legal range 1..4.
REQ-004 SHALL have parameter ZERO_R0, default 1: when 1, register 0 reads as zero and ignores writes.
REQ-005 SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-006 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-007 SHALL have port WriteReg, input, 1: write enable.
REQ-008 SHALL have port DstReg, input, ADDR_W: write index.
REQ-009 SHALL have port DstData, input, DATA_W: write data.
REQ-010 SHALL have port SrcReg, input, NUM_RD*ADDR_W: packed read indices; port p occupies bits [p*ADDR_W +: ADDR_W].
REQ-011 SHALL have port SrcData, output, NUM_RD*DATA_W: packed read data; port p occupies bits [p*DATA_W +: DATA_W].
REQ-012 SHALL have port WrCount, output, 8: saturating count of committed writes since reset.

Function
- REQ-013 SHALL, when WriteReg=1 and rst=0 at a rising clk edge, store DstData into register DstReg; one-cycle write latency.
- REQ-014 SHALL produce each SrcData port combinationally from the addressed register; zero-cycle read latency.
- REQ-015 SHALL drive a read of index 0 to all-zero when ZERO_R0=1, including during a same-cycle write to index 0.
- REQ-016 SHALL discard a write to index 0 when ZERO_R0=1; the write is not counted in WrCount.
- REQ-017 SHALL let all NUM_RD ports address the same index simultaneously and return identical data.
- REQ-018 SHALL select the write row with a one-hot wordline of width 2**ADDR_W; at most one bit is set, and no bit is set when WriteReg=0.
- REQ-019 SHALL increment WrCount by 1 per committed write and hold it at 255 (saturate, no wrap).
- REQ-020 SHALL leave register contents unchanged when WriteReg=0, regardless of DstReg or DstData.

Reset
- REQ-021 SHALL, while rst=1 at a rising clk edge, clear every register and WrCount to 0.
- REQ-022 SHALL give rst priority over a simultaneous write; the write is lost.
- REQ-023 SHALL output all-zero SrcData on every port in the first cycle after reset deasserts, for any SrcReg.

Configuration
- REQ-024 SHALL, with macro REG_FILE_BYPASS_EN defined, forward DstData to any read port whose SrcReg equals DstReg while WriteReg=1 in the same cycle.
  - Exception: index 0 when ZERO_R0=1.
  - No bypass while rst=1.
- REQ-025 SHALL, without REG_FILE_BYPASS_EN, return the pre-write register value on such a read; the new value is visible from the next cycle.

Structure
- REQ-026 SHALL take DATA_W, ADDR_W and NUM_RD defaults, plus the WrCount width constant, from shared package wisc_pkg.
- REQ-027 SHALL instantiate one sub-module, decoder_param: a parametrised ADDR_W to 2**ADDR_W one-hot decoder with enable, used for the write wordline.

Verification
- REQ-028 SHALL cover basic write/read:
  - Stimulus: reset, then write 0xBEEF to R5; next cycle read R5 on port 0 and port 1.
  - Response: both ports show 0xBEEF; WrCount=1.
- REQ-029 SHALL cover R0 protection (ZERO_R0=1):
  - Stimulus: write 0x1234 to R0, then read R0.
  - Response: SrcData=0x0000; WrCount unchanged.
- REQ-030 SHALL cover same-cycle write and read:
  - Stimulus: R3=0x0001 held; in one cycle write 0x00FF to R3 and read R3.
  - Response with REG_FILE_BYPASS_EN: 0x00FF in that cycle.
  - Response without it: 0x0001 in that cycle, then 0x00FF next cycle.
- REQ-031 SHALL cover reset priority:
  - Stimulus: write 0xAAAA to R7 in the same cycle rst=1.
  - Response: next cycle R7 reads 0x0000 and WrCount=0.
- REQ-032 SHALL cover WrCount saturation:
  - Stimulus: 300 consecutive writes to R1..R15 in rotation.
  - Response: WrCount=255 and holds; R15 holds its last written value.
- REQ-033 SHALL cover a non-default configuration:
  - Parameters: DATA_W=32, ADDR_W=5, NUM_RD=3.
  - Stimulus: write 0xDEADBEEF to R31; read R31, R0, R31 on ports 0, 1, 2.
  - Response: 0xDEADBEEF, 0x00000000, 0xDEADBEEF.
